clock_gate_ctrl: RTL and testbench

- Control end of the team's gated-clock cell: generates the enable that drives the cell's i_clock_en.
- Watches activity in the gated domain and closes the clock after a programmable idle period.
- Closes only after a sleep-request/acknowledge handshake with the domain.
- Reopens the clock on a wake request, waits a settle interval, then acknowledges the requester.

---
 rtl/clock_gate_pkg.sv | 13 +
 rtl/clock_gate_timer.sv | 40 ++++
 rtl/clock_gate_ctrl.sv | 150 +++++++++++++++
 tb/tb_clock_gate_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/clock_gate_pkg.sv
// Shared types and constants for the gated-clock controller.
package clock_gate_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    OFF   = 2'd2,
    WAKE  = 2'd3
  } cg_state_t;

  localparam int CG_STATS_W = 16;

endpackage

// File: rtl/clock_gate_timer.sv
// Loadable up-counter with a runtime terminal compare, shared by the idle and wake phases.
module clock_gate_timer #(
  parameter int CNT_W = 8
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_inc,
  input  logic [CNT_W-1:0] i_terminal,
  output logic             o_at_terminal
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign o_at_terminal = (count_q == i_terminal);

  // Holds at the terminal value so the count can never run past it or wrap.
  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_load) begin
      count_d = i_load_val;
    end else if (i_inc && !o_at_terminal) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/clock_gate_ctrl.sv
// Gated-clock enable controller: idle detection, sleep handshake, wake with settle.
// Optional gate-off event counter enabled by defining CLOCK_GATE_STATS_EN.
module clock_gate_ctrl
  import clock_gate_pkg::*;
#(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_busy,
  input  logic                  i_force_on,
  input  logic                  i_wake_req,
  input  logic                  i_sleep_ack,
  output logic                  o_sleep_req,
  output logic                  o_clock_en,
  output logic                  o_wake_ack,
  output logic [1:0]            o_state,
  output logic [CG_STATS_W-1:0] o_gate_count
);

  localparam logic [CNT_W-1:0] IDLE_TERM = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_TERM = CNT_W'(WAKE_CYCLES - 1);

  cg_state_t        state_q, state_d;
  logic             clock_en_q, clock_en_d;
  logic             sleep_req_q, sleep_req_d;
  logic             wake_ack_q, wake_ack_d;
  logic             idle;
  logic             tmr_clear;
  logic             tmr_inc;
  logic [CNT_W-1:0] tmr_terminal;
  logic             tmr_at_term;

  assign idle = !i_busy && !i_wake_req && !i_force_on;

  clock_gate_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_clear      (tmr_clear),
    .i_load       (1'b0),
    .i_load_val   ({CNT_W{1'b0}}),
    .i_inc        (tmr_inc),
    .i_terminal   (tmr_terminal),
    .o_at_terminal(tmr_at_term)
  );

  // Outputs are computed for the next state so they register alongside it.
  always_comb begin
    state_d      = state_q;
    clock_en_d   = 1'b1;
    sleep_req_d  = 1'b0;
    wake_ack_d   = 1'b0;
    tmr_clear    = 1'b1;
    tmr_inc      = 1'b0;
    tmr_terminal = IDLE_TERM;
    case (state_q)
      RUN: begin
        if (idle) begin
          if (tmr_at_term) begin
            state_d     = DRAIN;
            sleep_req_d = 1'b1;
          end else begin
            tmr_clear = 1'b0;
            tmr_inc   = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!idle) begin
          state_d = RUN;
        end else if (i_sleep_ack) begin
          state_d    = OFF;
          clock_en_d = 1'b0;
        end else begin
          sleep_req_d = 1'b1;
        end
      end
      OFF: begin
        if (i_wake_req || i_force_on) begin
          state_d = WAKE;
        end else begin
          clock_en_d = 1'b0;
        end
      end
      WAKE: begin
        tmr_terminal = WAKE_TERM;
        if (tmr_at_term) begin
          state_d    = RUN;
          wake_ack_d = 1'b1;
        end else begin
          tmr_clear = 1'b0;
          tmr_inc   = 1'b1;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= RUN;
      clock_en_q  <= 1'b1;
      sleep_req_q <= 1'b0;
      wake_ack_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clock_en_q  <= clock_en_d;
      sleep_req_q <= sleep_req_d;
      wake_ack_q  <= wake_ack_d;
    end
  end

  assign o_state     = state_q;
  assign o_clock_en  = clock_en_q;
  assign o_sleep_req = sleep_req_q;
  assign o_wake_ack  = wake_ack_q;

`ifdef CLOCK_GATE_STATS_EN
  logic [CG_STATS_W-1:0] gate_count_q, gate_count_d;
  logic                  gate_evt;

  assign gate_evt = (state_q == DRAIN) && (state_d == OFF);

  always_comb begin
    gate_count_d = gate_count_q;
    if (gate_evt && (gate_count_q != {CG_STATS_W{1'b1}})) begin
      gate_count_d = gate_count_q + 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      gate_count_q <= '0;
    end else begin
      gate_count_q <= gate_count_d;
    end
  end

  assign o_gate_count = gate_count_q;
`else
  assign o_gate_count = '0;
`endif

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Directed self-checking bench for clock_gate_ctrl with IDLE_CYCLES=4, WAKE_CYCLES=2.
module tb_clock_gate_ctrl;

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_OFF   = 2'd2;
  localparam logic [1:0] S_WAKE  = 2'd3;

`ifdef CLOCK_GATE_STATS_EN
  localparam logic [15:0] GC_ONE = 16'd1;
  localparam logic [15:0] GC_TWO = 16'd2;
`else
  localparam logic [15:0] GC_ONE = 16'd0;
  localparam logic [15:0] GC_TWO = 16'd0;
`endif

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_busy;
  logic        i_force_on;
  logic        i_wake_req;
  logic        i_sleep_ack;
  logic        o_sleep_req;
  logic        o_clock_en;
  logic        o_wake_ack;
  logic [1:0]  o_state;
  logic [15:0] o_gate_count;

  int compared   = 0;
  int mismatched = 0;

  clock_gate_ctrl #(
    .IDLE_CYCLES(4),
    .WAKE_CYCLES(2),
    .CNT_W      (8)
  ) dut (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_busy      (i_busy),
    .i_force_on  (i_force_on),
    .i_wake_req  (i_wake_req),
    .i_sleep_ack (i_sleep_ack),
    .o_sleep_req (o_sleep_req),
    .o_clock_en  (o_clock_en),
    .o_wake_ack  (o_wake_ack),
    .o_state     (o_state),
    .o_gate_count(o_gate_count)
  );

  always #5 i_clock = ~i_clock;

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Advance one clock edge, then settle so outputs show the new cycle.
  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge i_clock);
      #1;
    end
  endtask

  task automatic checkAll(input string tag, input logic [1:0] st, input logic ce,
                          input logic sr, input logic wa, input logic [15:0] gc);
    checkOutput({tag, ".state"}, {14'd0, o_state}, {14'd0, st});
    checkOutput({tag, ".clock_en"}, {15'd0, o_clock_en}, {15'd0, ce});
    checkOutput({tag, ".sleep_req"}, {15'd0, o_sleep_req}, {15'd0, sr});
    checkOutput({tag, ".wake_ack"}, {15'd0, o_wake_ack}, {15'd0, wa});
    checkOutput({tag, ".gate_count"}, o_gate_count, gc);
  endtask

  initial begin
    i_reset     = 1'b1;
    i_busy      = 1'b1;
    i_force_on  = 1'b0;
    i_wake_req  = 1'b0;
    i_sleep_ack = 1'b0;

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1);
      checkAll("reset", S_RUN, 1'b1, 1'b0, 1'b0, 16'd0);
    end
    i_reset = 1'b0;
    applyStimulus(1);
    checkAll("run_busy", S_RUN, 1'b1, 1'b0, 1'b0, 16'd0);

    // Idle from cycle t with ack tied high: DRAIN at t+4, OFF at t+5.
    i_busy      = 1'b0;
    i_sleep_ack = 1'b1;
    applyStimulus(3);
    checkAll("idle_t3", S_RUN, 1'b1, 1'b0, 1'b0, 16'd0);
    applyStimulus(1);
    checkAll("drain_t4", S_DRAIN, 1'b1, 1'b1, 1'b0, 16'd0);
    applyStimulus(1);
    checkAll("off_t5", S_OFF, 1'b0, 1'b0, 1'b0, GC_ONE);

    i_busy = 1'b1;
    applyStimulus(3);
    checkAll("off_busy_ignored", S_OFF, 1'b0, 1'b0, 1'b0, GC_ONE);

    // Wake request at cycle w.
    i_busy     = 1'b0;
    i_wake_req = 1'b1;
    applyStimulus(1);
    checkAll("wake_w1", S_WAKE, 1'b1, 1'b0, 1'b0, GC_ONE);
    applyStimulus(1);
    checkAll("wake_w2", S_WAKE, 1'b1, 1'b0, 1'b0, GC_ONE);
    applyStimulus(1);
    checkAll("wake_ack_w3", S_RUN, 1'b1, 1'b0, 1'b1, GC_ONE);
    applyStimulus(1);
    checkAll("wake_ack_w4", S_RUN, 1'b1, 1'b0, 1'b0, GC_ONE);
    applyStimulus(6);
    checkAll("wake_held_run", S_RUN, 1'b1, 1'b0, 1'b0, GC_ONE);

    // Idle restart: 3 idle, one busy, then DRAIN only after 4 more idle.
    i_wake_req  = 1'b0;
    i_sleep_ack = 1'b0;
    i_busy      = 1'b0;
    applyStimulus(3);
    i_busy = 1'b1;
    applyStimulus(1);
    i_busy = 1'b0;
    applyStimulus(3);
    checkAll("restart_p4", S_RUN, 1'b1, 1'b0, 1'b0, GC_ONE);
    applyStimulus(1);
    checkAll("restart_p5", S_DRAIN, 1'b1, 1'b1, 1'b0, GC_ONE);

    applyStimulus(5);
    checkAll("drain_waits", S_DRAIN, 1'b1, 1'b1, 1'b0, GC_ONE);

    // Abort has priority over sleep_ack.
    i_busy      = 1'b1;
    i_sleep_ack = 1'b1;
    applyStimulus(1);
    checkAll("abort_busy", S_RUN, 1'b1, 1'b0, 1'b0, GC_ONE);

    // Abort by force_on from DRAIN.
    i_busy      = 1'b0;
    i_sleep_ack = 1'b0;
    applyStimulus(4);
    checkAll("drain_again", S_DRAIN, 1'b1, 1'b1, 1'b0, GC_ONE);
    i_force_on  = 1'b1;
    i_sleep_ack = 1'b1;
    applyStimulus(1);
    checkAll("abort_force", S_RUN, 1'b1, 1'b0, 1'b0, GC_ONE);
    i_force_on = 1'b0;

    // Second gate-off, then reset while OFF.
    applyStimulus(5);
    checkAll("off_second", S_OFF, 1'b0, 1'b0, 1'b0, GC_TWO);
    i_reset = 1'b1;
    applyStimulus(1);
    checkAll("reset_in_off", S_RUN, 1'b1, 1'b0, 1'b0, 16'd0);
    i_reset = 1'b0;

    // force_on holds RUN indefinitely even with no activity.
    i_force_on  = 1'b1;
    i_sleep_ack = 1'b0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1);
      checkOutput("force_on_run", {14'd0, o_state}, {14'd0, S_RUN});
    end
    i_force_on = 1'b0;
    applyStimulus(3);
    checkAll("after_force_i3", S_RUN, 1'b1, 1'b0, 1'b0, 16'd0);
    applyStimulus(1);
    checkAll("after_force_i4", S_DRAIN, 1'b1, 1'b1, 1'b0, 16'd0);

    // Wake via force_on from OFF.
    i_sleep_ack = 1'b1;
    applyStimulus(1);
    checkAll("off_third", S_OFF, 1'b0, 1'b0, 1'b0, GC_ONE);
    i_force_on = 1'b1;
    applyStimulus(3);
    checkAll("force_wake_ack", S_RUN, 1'b1, 1'b0, 1'b1, GC_ONE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
